// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard RAW interlock, memory freeze and decode redirect control.
// Defining HAZARD_PERF_EN adds perf_raw/perf_mem stall-cycle counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_ra1,
  input  logic [4:0]  d_ra2,
  input  logic        d_use1,
  input  logic        d_use2,
  input  logic        d_wen,
  input  logic [4:0]  d_dst,
  input  logic        d_jump,
  input  logic [63:0] d_target,
  input  logic        w_valid,
  input  logic [4:0]  w_dst,
  input  logic        i_busy,
  input  logic        m_busy,
  output logic        stall_f,
  output logic        stall_d,
  output logic        bubble_e,
  output logic        freeze,
  output logic        flush_f,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        sb_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_raw,
  output logic [31:0] perf_mem
`endif
);
  typedef enum logic [1:0] {RUN, MWAIT, RWAIT, MRWAIT} state_t;
  state_t state, state_nx;
  logic [1:0] cnt [32];
  logic [31:0] inc_v, dec_v;
  logic raw, issue, run, jmp, err;
  assign run = state == RUN;
  assign freeze = state == MWAIT || state == MRWAIT;
  assign raw = d_valid && ((d_use1 && d_ra1 != 5'd0 && cnt[d_ra1] != 2'd0) ||
                           (d_use2 && d_ra2 != 5'd0 && cnt[d_ra2] != 2'd0) ||
                           (d_wen && d_dst != 5'd0 && cnt[d_dst] == 2'd3));
  assign issue = d_valid && !raw && !freeze && run;
  assign jmp = issue && d_jump;
  assign inc_v = 32'(issue && d_wen && d_dst != 5'd0) << d_dst;
  assign dec_v = 32'(w_valid && w_dst != 5'd0 && !freeze) << w_dst;
  assign err = dec_v[w_dst] && !inc_v[w_dst] && cnt[w_dst] == 2'd0;
  assign stall_f = freeze || (run && raw);
  assign stall_d = stall_f;
  assign bubble_e = state == RWAIT || (run && raw);
  assign flush_f = state == RWAIT;
  assign redirect_valid = state == RWAIT || state == MRWAIT;
  // A jump issuing into a memory stall keeps its redirect pending via MRWAIT.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = m_busy ? (jmp ? MRWAIT : MWAIT) : (jmp ? RWAIT : RUN);
      MWAIT:   state_nx = m_busy ? MWAIT : RUN;
      RWAIT:   state_nx = m_busy ? MRWAIT : (i_busy ? RWAIT : RUN);
      default: state_nx = m_busy ? MRWAIT : RWAIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      redirect_pc <= '0;
      sb_err <= 1'b0;
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      state <= state_nx;
      if (jmp) redirect_pc <= d_target;
      if (err) sb_err <= 1'b1;
      for (int i = 0; i < 32; i++)
        if (inc_v[i] && !dec_v[i]) cnt[i] <= cnt[i] + 2'd1;
        else if (dec_v[i] && !inc_v[i] && cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
    end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_raw <= '0;
      perf_mem <= '0;
    end else begin
      if (run && raw) perf_raw <= perf_raw + 32'd1;
      if (freeze) perf_mem <= perf_mem + 32'd1;
    end
`endif
endmodule
